rsc_frame_encoder: RTL

- 8-state recursive systematic convolutional encoder, rate 1/2, with trellis termination.
- Sits directly upstream of the Viterbi decoder. Converts a framed serial bit stream into (sys, parity) symbol pairs qualified by Data_Valid, in the decoder's input format.
- Uses the same trellis as the decoder: feedback polynomial 1+D^2+D^3, parity polynomial 1+D+D^3.
- Also serves as the loopback stimulus source for decoder regression.

---
 rtl/rsc_frame_encoder_if.sv | 23 ++
 rtl/rsc_frame_encoder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rsc_frame_encoder_if.sv
// Handshake and symbol bundle between a bit source, the RSC frame encoder and the decoder side.
// master = bit source / symbol consumer, slave = encoder.
interface rsc_frame_encoder_if;
  logic start;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic sys;
  logic parity;
  logic Data_Valid;
  logic busy;
  logic frame_done;

  modport master (
    output start, in_bit, in_valid,
    input  in_ready, sys, parity, Data_Valid, busy, frame_done
  );

  modport slave (
    input  start, in_bit, in_valid,
    output in_ready, sys, parity, Data_Valid, busy, frame_done
  );
endinterface

// File: rtl/rsc_frame_encoder.sv
// 8-state rate-1/2 RSC encoder (feedback 1+D^2+D^3, parity 1+D+D^3) producing framed symbols.
// Define RSC_TERMINATE_EN to append 3 tail symbols that drive the trellis back to state 0.
module rsc_frame_encoder #(
  parameter int unsigned FRAME_LEN = 61,
  parameter int unsigned CNT_W     = 6
) (
  input logic                 clk,
  input logic                 rst,
  rsc_frame_encoder_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StEncode, StTail, StDone} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tail_q, tail_d;
  logic             sys_q, sys_d;
  logic             par_q, par_d;
  logic             dv_q, dv_d;
  logic             done_q, done_d;

  logic fire;
  logic u;
  logic a;
  logic par;

  // Trellis step; in TAIL, u is chosen so the feedback bit a is forced to 0.
  always_comb begin
    fire = 1'b0;
    u    = 1'b0;
    unique case (state_q)
      StEncode: begin
        fire = bus.in_valid;
        u    = bus.in_bit;
      end
      StTail: begin
        fire = 1'b1;
        u    = s_q[1] ^ s_q[2];
      end
      default: ;
    endcase
    a   = u ^ s_q[1] ^ s_q[2];
    par = a ^ s_q[0] ^ s_q[2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      sys_q   <= 1'b0;
      par_q   <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      sys_q   <= sys_d;
      par_q   <= par_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    s_d     = fire ? {s_q[1:0], a} : s_q;
    sys_d   = fire ? u : sys_q;
    par_d   = fire ? par : par_q;
    dv_d    = fire;
    done_d  = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StEncode;
          s_d     = '0;
          cnt_d   = '0;
        end
      end
      StEncode: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastIdx) begin
`ifdef RSC_TERMINATE_EN
            state_d = StTail;
            tail_d  = '0;
`else
            state_d = StDone;
`endif
          end
        end
      end
      StTail: begin
        tail_d = tail_q + 2'd1;
        if (tail_q == 2'd2) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == StEncode);
    bus.busy       = (state_q == StEncode) || (state_q == StTail);
    bus.sys        = sys_q;
    bus.parity     = par_q;
    bus.Data_Valid = dv_q;
    bus.frame_done = done_q;
  end

endmodule
